// File: rtl/demux_1_2_64_q.sv
// Buffered 1-to-2 demultiplexer: one valid/ready input is steered by in_sel into
// one of two independent DEPTH-entry FIFO lanes, each with its own valid/ready output.
module demux_1_2_64_q #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in_sel,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out0_valid,
  output logic [WIDTH-1:0]             out0_data,
  input  logic                         out0_ready,
  output logic                         out1_valid,
  output logic [WIDTH-1:0]             out1_data,
  input  logic                         out1_ready,
  output logic [$clog2(DEPTH+1)-1:0]   out0_count,
  output logic [$clog2(DEPTH+1)-1:0]   out1_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]    lane_count [2];
  logic [WIDTH-1:0] lane_head  [2];
  logic [1:0]       lane_push;
  logic [1:0]       lane_ready;
  logic             in_accept;

  // Readiness looks only at the registered occupancy of the selected lane, so a
  // pop in the same cycle never frees a slot for a push.
  assign in_ready   = (in_sel ? lane_count[1] : lane_count[0]) != CW'(DEPTH);
  assign in_accept  = in_valid && in_ready;
  assign lane_push  = {in_accept && in_sel, in_accept && !in_sel};
  assign lane_ready = {out1_ready, out0_ready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [WIDTH-1:0] mem_d [DEPTH];
      logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
      logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
      logic [CW-1:0]    count_q, count_d;
      logic             push, pop;

      assign push = lane_push[gi];
      assign pop  = (count_q != '0) && lane_ready[gi];

      always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
          mem_d[wr_ptr_q] = in_data;
          wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
          count_q  <= '0;
          for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
          end
        end else begin
          rd_ptr_q <= rd_ptr_d;
          wr_ptr_q <= wr_ptr_d;
          count_q  <= count_d;
          for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
          end
        end
      end

      assign lane_count[gi] = count_q;
      assign lane_head[gi]  = mem_q[rd_ptr_q];
    end
  endgenerate

  assign out0_count = lane_count[0];
  assign out1_count = lane_count[1];
  assign out0_valid = (lane_count[0] != '0);
  assign out1_valid = (lane_count[1] != '0);
  assign out0_data  = lane_head[0];
  assign out1_data  = lane_head[1];

endmodule

// File: tb/tb_demux_1_2_64_q.sv
// Self-checking bench for demux_1_2_64_q: directed steps plus a random phase,
// all compared against a queue-based reference of the two lanes.
module tb_demux_1_2_64_q;
  localparam int WIDTH = 64;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out0_valid, out1_valid;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_ready, out1_ready;
  logic [CW-1:0]    out0_count, out1_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  demux_1_2_64_q #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
    .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
    .out0_count(out0_count), .out1_count(out1_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".out0_valid"}, WIDTH'(out0_valid), WIDTH'(q0.size() != 0));
    check({tag, ".out1_valid"}, WIDTH'(out1_valid), WIDTH'(q1.size() != 0));
    check({tag, ".out0_count"}, WIDTH'(out0_count), WIDTH'(q0.size()));
    check({tag, ".out1_count"}, WIDTH'(out1_count), WIDTH'(q1.size()));
    if (q0.size() != 0) check({tag, ".out0_data"}, out0_data, q0[0]);
    if (q1.size() != 0) check({tag, ".out1_data"}, out1_data, q1[0]);
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
  task automatic cycle(input string tag, input logic v, input logic sel,
                       input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    bit exp_ready, do_push, pop0, pop1;
    in_valid = v; in_sel = sel; in_data = d; out0_ready = r0; out1_ready = r1;
    #1;
    exp_ready = sel ? (q1.size() != DEPTH) : (q0.size() != DEPTH);
    check({tag, ".in_ready"}, WIDTH'(in_ready), WIDTH'(exp_ready));
    do_push = v && exp_ready;
    pop0 = r0 && (q0.size() != 0);
    pop1 = r1 && (q1.size() != 0);
    @(posedge clk);
    #1;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (do_push) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    check_state(tag);
    $display("[TB] %s v=%0d sel=%0d d=%h r0=%0d r1=%0d -> cnt0=%0d cnt1=%0d",
             tag, v, sel, d, r0, r1, out0_count, out1_count);
  endtask

  task automatic do_reset(input string tag, input int n, input logic v);
    reset = 1'b1; in_valid = v; in_sel = 1'b0; in_data = 64'hDEAD_BEEF_0000_0099;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    q0.delete(); q1.delete();
    check_state(tag);
    check({tag, ".out0_data"}, out0_data, '0);
    check({tag, ".out1_data"}, out1_data, '0);
    #1;
    check({tag, ".in_ready"}, WIDTH'(in_ready), WIDTH'(1'b1));
    $display("[TB] %s reset applied for %0d cycles", tag, n);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    @(posedge clk); #1;

    do_reset("reset_idle", 2, 1'b0);

    // Steering with both consumers stalled
    cycle("steer0", 1, 0, 64'hAAAA_0000_0000_0001, 0, 0);
    cycle("steer1", 1, 1, 64'h5555_0000_0000_0002, 0, 0);
    cycle("steer_hold", 0, 0, '0, 0, 0);
    check("steer.out0_data_const", out0_data, 64'hAAAA_0000_0000_0001);
    check("steer.out1_data_const", out1_data, 64'h5555_0000_0000_0002);
    do_reset("reset_b", 1, 1'b0);

    // Fill lane 0, backpressure, then release one pop
    cycle("fill_a", 1, 0, 64'h10, 0, 0);
    cycle("fill_b", 1, 0, 64'h11, 0, 0);
    cycle("full_sel1_probe", 0, 1, '0, 0, 0);
    cycle("held_push", 1, 0, 64'h12, 0, 0);
    check("full.out0_count_const", WIDTH'(out0_count), WIDTH'(2));
    cycle("pop_release", 1, 0, 64'h12, 1, 0);
    cycle("held_enters", 1, 0, 64'h12, 0, 0);
    check("order.head_0x11", out0_data, 64'h11);
    cycle("drain_a", 0, 0, '0, 1, 0);
    check("order.head_held", out0_data, 64'h12);
    cycle("drain_b", 0, 0, '0, 1, 0);

    // Streaming into lane 1 with pointer wrap
    for (int i = 1; i <= 8; i++) begin
      cycle("stream", 1, 1, WIDTH'(i), 0, 1);
      check("stream.head", out1_data, WIDTH'(i));
    end
    cycle("stream_tail", 0, 1, '0, 0, 1);

    // Simultaneous push/pop on lane 0 at count 1
    cycle("sim_setup", 1, 0, 64'h21, 0, 0);
    cycle("sim_pushpop", 1, 0, 64'h22, 1, 0);
    check("sim.head_0x22", out0_data, 64'h22);
    cycle("sim_drain", 0, 0, '0, 1, 0);

    // Reset mid-operation with a push pending
    cycle("mid_a", 1, 0, 64'h31, 0, 0);
    cycle("mid_b", 1, 0, 64'h32, 0, 0);
    cycle("mid_c", 1, 1, 64'h33, 0, 0);
    do_reset("reset_mid", 1, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), {$urandom, $urandom},
            1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
